// File: rtl/qspi_rom_reader.sv
// Host-side QSPI read controller. It sends command, address and dummy cycles,
// then samples two data nibbles per byte. While reads stay sequential the
// device stays selected and sclk is simply paused, so later bytes stream out
// without a new command.
module qspi_rom_reader #(
  parameter int          ADDR_BITS     = 24,
  parameter logic [7:0]  CMD_BYTE      = 8'hEB,
  parameter int          DUMMY_CYCLES  = 7,
  parameter int          SCLK_HALF     = 2,
  parameter int          DESELECT_CLKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 o_ready,
  output logic                 o_data_valid,
  output logic [7:0]           o_data,
  output logic                 o_qspi_sclk,
  output logic                 o_qspi_select,
  output logic [3:0]           o_qspi_io_out,
  output logic                 o_qspi_io_oe,
  input  logic [3:0]           i_qspi_io_in
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DESEL = 3'd6
  } state_t;

  localparam int NIBS = ADDR_BITS / 4;
  localparam int TW   = 8 + ADDR_BITS;
  localparam int PW   = $clog2(2 * SCLK_HALF);
  localparam int CW   = 8;

  state_t               r_state, w_state_next;
  logic [PW-1:0]        r_ph;
  logic [CW-1:0]        r_cnt, r_dcnt;
  logic                 r_wait, r_pending, r_nvalid;
  logic [ADDR_BITS-1:0] r_addr, r_next_addr;
  logic [TW-1:0]        r_tx;
  logic [7:0]           r_rx, r_data;
  logic                 r_ready, r_valid, r_sclk, r_select, r_oe;
  logic [3:0]           r_io_out;
  logic                 w_active, w_run, w_rise, w_samp, w_fall, w_accept, w_seq;

  // Phase decode: r_wait inserts one settle clk after select falls or a
  // streamed read is accepted, before the first low phase begins.
  assign w_active = (r_state == ST_CMD) || (r_state == ST_ADDR) ||
                    (r_state == ST_DUMMY) || (r_state == ST_DATA);
  assign w_run    = w_active && !r_wait;
  assign w_rise   = w_run && (r_ph == PW'(SCLK_HALF - 1));
  assign w_samp   = w_run && (r_ph == PW'(2 * SCLK_HALF - 2));
  assign w_fall   = w_run && (r_ph == PW'(2 * SCLK_HALF - 1));
  assign w_accept = i_req && r_ready;
  assign w_seq    = r_nvalid && (i_addr == r_next_addr);

  assign o_ready       = r_ready;
  assign o_data_valid  = r_valid;
  assign o_data        = r_data;
  assign o_qspi_sclk   = r_sclk;
  assign o_qspi_select = r_select;
  assign o_qspi_io_out = r_io_out;
  assign o_qspi_io_oe  = r_oe;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; phase transitions happen on the sclk falling edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_CMD; else w_state_next = ST_IDLE;
      ST_CMD:   if (w_fall && r_cnt == CW'(7)) w_state_next = ST_ADDR;
                else w_state_next = ST_CMD;
      ST_ADDR:  if (w_fall && r_cnt == CW'(NIBS - 1)) w_state_next = ST_DUMMY;
                else w_state_next = ST_ADDR;
      ST_DUMMY: if (w_fall && r_cnt == CW'(DUMMY_CYCLES - 1)) w_state_next = ST_DATA;
                else w_state_next = ST_DUMMY;
      ST_DATA:  if (w_fall && r_cnt == CW'(1)) w_state_next = ST_HOLD;
                else w_state_next = ST_DATA;
      ST_HOLD: begin
        if (w_accept) w_state_next = w_seq ? ST_DATA : ST_DESEL;
        else          w_state_next = ST_HOLD;
      end
      ST_DESEL: begin
        if (r_dcnt == CW'(DESELECT_CLKS - 1)) w_state_next = r_pending ? ST_CMD : ST_IDLE;
        else                                  w_state_next = ST_DESEL;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: sclk generation, command/address shifting, nibble capture and
  // the host-side handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph        <= '0;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_wait      <= 1'b0;
      r_pending   <= 1'b0;
      r_nvalid    <= 1'b0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_tx        <= '0;
      r_rx        <= 8'h00;
      r_data      <= 8'h00;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
      r_sclk      <= 1'b0;
      r_select    <= 1'b1;
      r_oe        <= 1'b0;
      r_io_out    <= 4'h0;
    end else begin
      r_valid  <= 1'b0;
      r_wait   <= ((w_state_next == ST_CMD) && (r_state != ST_CMD)) ||
                  ((w_state_next == ST_DATA) && (r_state == ST_HOLD));
      r_select <= (w_state_next == ST_IDLE) || (w_state_next == ST_DESEL);

      if (w_run) r_ph <= w_fall ? '0 : r_ph + PW'(1);
      else       r_ph <= '0;

      if (w_state_next != r_state) r_cnt <= '0;
      else if (w_fall)             r_cnt <= r_cnt + CW'(1);

      if (r_state == ST_DESEL) r_dcnt <= r_dcnt + CW'(1);
      else                     r_dcnt <= '0;

      if (w_rise)                  r_sclk <= 1'b1;
      else if (w_fall || !w_active) r_sclk <= 1'b0;

      // io only changes on the edge that raises sclk
      if (w_accept) begin
        r_ready   <= 1'b0;
        r_addr    <= i_addr;
        r_tx      <= {CMD_BYTE, i_addr};
        r_pending <= (r_state == ST_HOLD) && !w_seq;
        r_nvalid  <= (r_state == ST_HOLD) && w_seq;
      end else if (w_rise) begin
        case (r_state)
          ST_CMD: begin
            r_io_out <= {3'b000, r_tx[TW-1]};
            r_oe     <= 1'b1;
            r_tx     <= {r_tx[TW-2:0], 1'b0};
          end
          ST_ADDR: begin
            r_io_out <= r_tx[TW-1 -: 4];
            r_oe     <= 1'b1;
            r_tx     <= {r_tx[TW-5:0], 4'b0000};
          end
          default: begin
            r_io_out <= 4'h0;
            r_oe     <= 1'b0;
          end
        endcase
      end

      if ((r_state == ST_DATA) && w_samp) r_rx <= {r_rx[3:0], i_qspi_io_in};

      if ((r_state == ST_DATA) && (w_state_next == ST_HOLD)) begin
        r_data      <= r_rx;
        r_valid     <= 1'b1;
        r_ready     <= 1'b1;
        r_next_addr <= r_addr + ADDR_BITS'(1);
        r_nvalid    <= 1'b1;
      end

      if ((r_state == ST_DESEL) && (w_state_next != ST_DESEL)) begin
        r_pending <= 1'b0;
        r_ready   <= (w_state_next == ST_IDLE);
      end
    end
  end

endmodule
